// File: rtl/pcm_slot_rx.sv
// PCM timeslot receiver: locks to FSYNC, counts bits/slots, and extracts one
// 8-bit timeslot per frame as an A-law code word (optionally even-bit inverted).
module pcm_slot_rx #(
  parameter int SLOTS    = 32,
  parameter int SLOT_SEL = 1,
  parameter int INVERT   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BIT_EN,
  input  logic       SDATA,
  input  logic       FSYNC,
  output logic [7:0] CODE,
  output logic       CODE_VALID,
  output logic       LOCKED,
  output logic       SYNC_ERR
);

  localparam int SW = $clog2(SLOTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);
  localparam logic [SW-1:0] SEL_SLOT  = SW'(SLOT_SEL);
  localparam logic [7:0]    MASK      = (INVERT != 0) ? 8'h55 : 8'h00;

  typedef enum logic {HUNT = 1'b0, SYNC = 1'b1} state_t;

  // Handshake: BIT_EN is a qualifier strobe with no backpressure; SDATA/FSYNC
  // are consumed only when it is high. CODE_VALID is a one-cycle pulse and CODE
  // stays stable until the next pulse.
  state_t        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    miss_q, miss_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic       at_exp;
  logic [7:0] shifted;

  assign at_exp  = (slot_q == '0) && (bit_q == 3'd0);
  assign shifted = {shreg_q[6:0], SDATA};

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    shreg_d = shreg_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (BIT_EN) begin
      case (state_q)
        HUNT: begin
          if (FSYNC) begin
            state_d = SYNC;
            bit_d   = 3'd1;
            slot_d  = '0;
            miss_d  = 2'd0;
            shreg_d = {7'b0, SDATA};
          end
        end
        SYNC: begin
          if (FSYNC && !at_exp) begin
            // Misplaced sync: this bit becomes slot 0 bit 0; partial byte dropped.
            err_d   = 1'b1;
            bit_d   = 3'd1;
            slot_d  = '0;
            shreg_d = {7'b0, SDATA};
          end else begin
            shreg_d = shifted;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
              if (slot_q == SEL_SLOT) begin
                code_d  = shifted ^ MASK;
                valid_d = 1'b1;
              end
            end
            if (FSYNC) begin
              miss_d = 2'd0;
            end else if (at_exp) begin
              err_d = 1'b1;
              if (miss_q == 2'd1) begin
                state_d = HUNT;
                bit_d   = 3'd0;
                slot_d  = '0;
                miss_d  = 2'd0;
              end else begin
                miss_d = miss_q + 2'd1;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HUNT;
      bit_q   <= 3'd0;
      slot_q  <= '0;
      miss_q  <= 2'd0;
      shreg_q <= 8'h00;
      code_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      miss_q  <= miss_d;
      shreg_q <= shreg_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign CODE       = code_q;
  assign CODE_VALID = valid_q;
  assign LOCKED     = (state_q == SYNC);
  assign SYNC_ERR   = err_q;

endmodule

// File: tb/tb_pcm_slot_rx.sv
// Bench for pcm_slot_rx: two instances (INVERT=1 and INVERT=0) share stimulus and
// are compared every cycle against a position/bit-history model plus directed checks.
module tb_pcm_slot_rx;
  localparam int SLOTS    = 4;
  localparam int SLOT_SEL = 1;
  localparam int FBITS    = SLOTS * 8;

  logic       CLK = 1'b0;
  logic       RST, BIT_EN, SDATA, FSYNC;
  logic [7:0] code1, code0;
  logic       valid1, valid0, locked1, locked0, err1, err0;

  always #5 CLK = ~CLK;

  pcm_slot_rx #(.SLOTS(SLOTS), .SLOT_SEL(SLOT_SEL), .INVERT(1)) dut1 (
    .CLK(CLK), .RST(RST), .BIT_EN(BIT_EN), .SDATA(SDATA), .FSYNC(FSYNC),
    .CODE(code1), .CODE_VALID(valid1), .LOCKED(locked1), .SYNC_ERR(err1));

  pcm_slot_rx #(.SLOTS(SLOTS), .SLOT_SEL(SLOT_SEL), .INVERT(0)) dut0 (
    .CLK(CLK), .RST(RST), .BIT_EN(BIT_EN), .SDATA(SDATA), .FSYNC(FSYNC),
    .CODE(code0), .CODE_VALID(valid0), .LOCKED(locked0), .SYNC_ERR(err0));

  int n_pass = 0;
  int n_total = 0;
  int vcnt = 0;
  int ecnt = 0;

  // Reference model: frame position as a plain integer and a history of received bits.
  logic       m_locked = 1'b0;
  int         m_pos = 0;
  int         m_miss = 0;
  logic       m_hist[$];
  logic [7:0] m_code1 = 8'h00, m_code0 = 8'h00;
  logic       m_valid = 1'b0, m_err = 1'b0;

  typedef struct {
    logic       rst, en, sd, fs;
    logic [7:0] code1, code0;
    logic       valid, locked, err;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input logic r, input logic en, input logic sd, input logic fs);
    logic [7:0] b;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_locked = 1'b0; m_pos = 0; m_miss = 0; m_hist.delete();
      m_code1 = 8'h00; m_code0 = 8'h00;
    end else if (en) begin
      if (!m_locked) begin
        if (fs) begin
          m_locked = 1'b1; m_pos = 1; m_miss = 0;
          m_hist.delete(); m_hist.push_back(sd);
        end
      end else if (fs && m_pos != 0) begin
        m_err = 1'b1; m_pos = 1;
        m_hist.delete(); m_hist.push_back(sd);
      end else begin
        m_hist.push_back(sd);
        if (m_hist.size() > 8) void'(m_hist.pop_front());
        if (fs) m_miss = 0;
        else if (m_pos == 0) begin m_err = 1'b1; m_miss++; end
        if (m_miss == 2) begin
          m_locked = 1'b0; m_pos = 0; m_miss = 0;
        end else begin
          if (m_pos == SLOT_SEL * 8 + 7 && m_hist.size() == 8) begin
            for (int k = 0; k < 8; k++) b[7-k] = m_hist[k];
            m_code0 = b;
            m_code1 = b ^ 8'h55;
            m_valid = 1'b1;
          end
          m_pos = (m_pos + 1) % FBITS;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic en, input logic sd, input logic fs);
    RST = r; BIT_EN = en; SDATA = sd; FSYNC = fs;
    @(posedge CLK);
    model_step(r, en, sd, fs);
    #1;
    check("model_inv1", {21'd0, code1, valid1, locked1, err1},
          {21'd0, m_code1, m_valid, m_locked, m_err});
    check("model_inv0", {21'd0, code0, valid0, locked0, err0},
          {21'd0, m_code0, m_valid, m_locked, m_err});
    if (valid1) vcnt++;
    if (err1) ecnt++;
  endtask

  // Sends the first nbits of a frame; slot SLOT_SEL carries s1, other slots random.
  task automatic send_frame(input logic [7:0] s1, input bit fs, input int nbits, input int gmax);
    logic sd;
    for (int i = 0; i < nbits; i++) begin
      repeat ($urandom_range(0, gmax)) tick(1'b0, 1'b0, 1'($urandom), 1'($urandom));
      if (i >= 8 && i < 16) sd = s1[3'(15 - i)];
      else sd = 1'($urandom);
      tick(1'b0, 1'b1, sd, fs && (i == 0));
    end
  endtask

  initial begin
    logic [7:0] d;
    int tb_pos;
    logic r, en, fs;

    // Idle HUNT strobes, then one locked frame with slot 1 = D5 and a held cycle.
    d = 8'hD5;
    for (int i = 0; i < 2; i++)
      tbl.push_back('{rst:1'b0, en:1'b1, sd:1'b1, fs:1'b0, code1:8'h00, code0:8'h00,
                      valid:1'b0, locked:1'b0, err:1'b0});
    for (int i = 0; i < FBITS; i++) begin
      tbl.push_back('{rst:1'b0, en:1'b1, sd:(i >= 8 && i < 16) ? d[3'(15 - i)] : 1'b0,
                      fs:(i == 0), code1:(i >= 15) ? 8'h80 : 8'h00,
                      code0:(i >= 15) ? 8'hD5 : 8'h00, valid:(i == 15), locked:1'b1, err:1'b0});
      if (i == 15)
        tbl.push_back('{rst:1'b0, en:1'b0, sd:1'b1, fs:1'b1, code1:8'h80, code0:8'hD5,
                        valid:1'b0, locked:1'b1, err:1'b0});
    end

    RST = 1'b1; BIT_EN = 1'b0; SDATA = 1'b0; FSYNC = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_outputs", {20'd0, code1, valid1, locked1, err1, code0, valid0}, 32'd0);

    foreach (tbl[n]) begin
      tick(tbl[n].rst, tbl[n].en, tbl[n].sd, tbl[n].fs);
      check($sformatf("tbl%0d", n),
            {13'd0, code1, code0, valid1, locked1, err1},
            {13'd0, tbl[n].code1, tbl[n].code0, tbl[n].valid, tbl[n].locked, tbl[n].err});
    end

    // Inversion on/off with gapped strobes.
    vcnt = 0; ecnt = 0;
    send_frame(8'h2A, 1'b1, FBITS, 2);
    check("inv_on_2a", 32'(code1), 32'h7F);
    check("inv_off_2a", 32'(code0), 32'h2A);
    check("inv_vcnt", vcnt, 1);

    // FSYNC arrives when slot 1 bit 3 is expected.
    vcnt = 0; ecnt = 0;
    send_frame(8'h11, 1'b1, 11, 0);
    send_frame(8'h3C, 1'b1, FBITS, 1);
    check("misplaced_err", ecnt, 1);
    check("misplaced_vcnt", vcnt, 1);
    check("misplaced_code", 32'(code1), 32'h69);

    // One missing FSYNC, then a good frame, then two misses.
    vcnt = 0; ecnt = 0;
    send_frame(8'h96, 1'b0, FBITS, 0);
    send_frame(8'h5A, 1'b1, FBITS, 0);
    check("miss1_err", ecnt, 1);
    check("miss1_locked", 32'(locked1), 32'd1);
    check("miss1_code", 32'(code1), 32'h0F);
    ecnt = 0;
    send_frame(8'hE7, 1'b0, FBITS, 0);
    send_frame(8'h18, 1'b0, FBITS, 0);
    check("miss2_err", ecnt, 2);
    check("miss2_unlocked", 32'(locked1), 32'd0);
    check("miss2_code_kept", 32'(code1), 32'hB2);

    // Reset mid-slot, then no capture until relock and a full slot 1.
    send_frame(8'h24, 1'b1, FBITS, 0);
    check("relock_code", 32'(code1), 32'h71);
    send_frame(8'hC3, 1'b1, 12, 0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    check("midreset_outputs", {20'd0, code1, valid1, locked1, err1, code0, valid0}, 32'd0);
    vcnt = 0;
    send_frame(8'hFF, 1'b0, FBITS, 0);
    check("midreset_no_valid", vcnt, 0);
    send_frame(8'h81, 1'b1, FBITS, 0);
    check("midreset_vcnt", vcnt, 1);
    check("midreset_code", 32'(code1), 32'hD4);

    // Back-to-back strobes for three frames.
    vcnt = 0; send_frame(8'h55, 1'b1, FBITS, 0);
    check("b2b_code0", 32'(code1), 32'h00);
    check("b2b_vcnt0", vcnt, 1);
    vcnt = 0; send_frame(8'hAA, 1'b1, FBITS, 0);
    check("b2b_code1", 32'(code1), 32'hFF);
    check("b2b_vcnt1", vcnt, 1);
    vcnt = 0; send_frame(8'h00, 1'b1, FBITS, 0);
    check("b2b_code2", 32'(code1), 32'h55);
    check("b2b_vcnt2", vcnt, 1);

    // Random traffic: mostly well-placed FSYNC, occasional stray/missing ones and resets.
    tb_pos = 0;
    for (int c = 0; c < 3000; c++) begin
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 2) != 0);
      fs = en && ((tb_pos == 0 && $urandom_range(0, 9) != 0) || $urandom_range(0, 99) == 0);
      tick(r, en, 1'($urandom), fs);
      if (en && !r) tb_pos = (tb_pos + 1) % FBITS;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
